// File: rtl/button_press_conditioner.sv
// Conditions raw active-low push-buttons into clean single-cycle press events:
// synchronise, debounce, detect new presses, and lock out until all are released.
module button_press_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] key_n,
    input  logic                   enable,
    output logic                   press_valid,
    output logic [NUM_BUTTONS-1:0] press_onehot,
    output logic [1:0]             press_index,
    output logic                   multi_press,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   locked
);

    localparam int PC_W = $clog2(NUM_BUTTONS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [NUM_BUTTONS-1:0] BTN_ZERO = {NUM_BUTTONS{1'b0}};

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_BUTTONS-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [1:0] encode_index(input logic [NUM_BUTTONS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NUM_BUTTONS-1:0] sync1_r;
    logic [NUM_BUTTONS-1:0] sync2_r;
    logic [NUM_BUTTONS-1:0] stable_r;
    logic [NUM_BUTTONS-1:0] stable_d_r;
    logic [CNT_WIDTH-1:0]   cnt_r [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] rise_s;
    logic [PC_W-1:0]        down_count_s;

    state_t                 state_r;
    state_t                 state_next_s;

    logic                   valid_next_s;
    logic [NUM_BUTTONS-1:0] onehot_next_s;
    logic [1:0]             index_next_s;
    logic                   multi_next_s;

    logic                   press_valid_r;
    logic [NUM_BUTTONS-1:0] press_onehot_r;
    logic [1:0]             press_index_r;
    logic                   multi_press_r;

    // Two-flop synchroniser on the inverted (active-high) raw keys.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= BTN_ZERO;
            sync2_r <= BTN_ZERO;
        end else begin
            sync1_r <= ~key_n;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: a level must persist DEBOUNCE_CYCLES edges to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r <= BTN_ZERO;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the debounced state for press (0->1) detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d_r <= BTN_ZERO;
        end else begin
            stable_d_r <= stable_r;
        end
    end

    assign rise_s       = stable_r & ~stable_d_r;
    assign down_count_s = popcount(stable_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ARMED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: any new press locks; full release re-arms.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARMED: begin
                if (|rise_s) begin
                    state_next_s = LOCKED;
                end else begin
                    state_next_s = ARMED;
                end
            end
            LOCKED: begin
                if (stable_r == BTN_ZERO) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: state_next_s = ARMED;
        endcase
    end

    // FSM outputs: a lone press is reported, overlapping presses are flagged instead.
    always_comb begin
        valid_next_s  = 1'b0;
        onehot_next_s = BTN_ZERO;
        index_next_s  = 2'd0;
        multi_next_s  = 1'b0;
        case (state_r)
            ARMED: begin
                if ((|rise_s) && enable) begin
                    if (down_count_s == PC_W'(1)) begin
                        valid_next_s  = 1'b1;
                        onehot_next_s = stable_r;
                        index_next_s  = encode_index(stable_r);
                    end else begin
                        multi_next_s  = 1'b1;
                    end
                end else begin
                    valid_next_s = 1'b0;
                    multi_next_s = 1'b0;
                end
            end
            LOCKED: begin
                valid_next_s = 1'b0;
                multi_next_s = 1'b0;
            end
            default: begin
                valid_next_s = 1'b0;
                multi_next_s = 1'b0;
            end
        endcase
    end

    // Registered event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_valid_r  <= 1'b0;
            press_onehot_r <= BTN_ZERO;
            press_index_r  <= 2'd0;
            multi_press_r  <= 1'b0;
        end else begin
            press_valid_r  <= valid_next_s;
            press_onehot_r <= onehot_next_s;
            press_index_r  <= index_next_s;
            multi_press_r  <= multi_next_s;
        end
    end

    assign press_valid  = press_valid_r;
    assign press_onehot = press_onehot_r;
    assign press_index  = press_index_r;
    assign multi_press  = multi_press_r;
    assign held         = stable_r;
    assign locked       = (state_r == LOCKED);

endmodule

// File: tb/tb_button_press_conditioner.sv
// Scoreboard bench for button_press_conditioner with a short debounce window.
module tb_button_press_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic       enable;
    logic       press_valid;
    logic [3:0] press_onehot;
    logic [1:0] press_index;
    logic       multi_press;
    logic [3:0] held;
    logic       locked;

    typedef struct {
        logic       mp;
        logic [3:0] oh;
        logic [1:0] idx;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    button_press_conditioner #(
        .NUM_BUTTONS(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .enable(enable),
        .press_valid(press_valid),
        .press_onehot(press_onehot),
        .press_index(press_index),
        .multi_press(multi_press),
        .held(held),
        .locked(locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic mp, input logic [3:0] oh, input logic [1:0] idx, input int c);
        ev_t e;
        e.mp  = mp;
        e.oh  = oh;
        e.idx = idx;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every emitted event must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (press_valid || multi_press) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: valid=%b multi=%b onehot=%b index=%0d at cyc=%0d, none expected",
                             press_valid, multi_press, press_onehot, press_index, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", 32'(cyc), 32'(e.cyc));
                    check("ev_valid", 32'(press_valid), 32'(!e.mp));
                    check("ev_multi", 32'(multi_press), 32'(e.mp));
                    check("ev_onehot", 32'(press_onehot), 32'(e.oh));
                    check("ev_index", 32'(press_index), 32'(e.idx));
                end
            end else begin
                check("idle_fields_zero", 32'({press_onehot, press_index}), 32'd0);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        key_n  = 4'b1111;
        enable = 1'b0;

        // Reset state
        tick(20);
        check("rst_valid", 32'(press_valid), 32'd0);
        check("rst_multi", 32'(multi_press), 32'd0);
        check("rst_onehot", 32'(press_onehot), 32'd0);
        check("rst_index", 32'(press_index), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        reset = 1'b0;
        tick(2);
        check("post_rst_held", 32'(held), 32'd0);
        check("post_rst_locked", 32'(locked), 32'd0);

        // Single press of key 1 with exact latency
        enable = 1'b1;
        key_n  = 4'b1101;
        expect_ev(1'b0, 4'b0010, 2'd1, cyc + 7);
        tick(5);
        check("t2_held_before", 32'(held), 32'd0);
        tick(1);
        check("t2_held_after", 32'(held), 32'b0010);
        tick(2);
        check("t2_locked", 32'(locked), 32'd1);
        key_n = 4'b1111;
        tick(8);
        check("t2_released_locked", 32'(locked), 32'd0);
        check("t2_released_held", 32'(held), 32'd0);

        // Bounces of key 0 shorter than the debounce window
        for (int r = 0; r < 5; r++) begin
            key_n = 4'b1110;
            tick(3);
            key_n = 4'b1111;
            tick(3);
            check("t3_bounce_held0", 32'(held[0]), 32'd0);
        end
        tick(4);

        // Simultaneous press of keys 3 and 0
        key_n = 4'b0110;
        expect_ev(1'b1, 4'b0000, 2'd0, cyc + 7);
        tick(6);
        check("t4_held_multi", 32'(held), 32'b1001);
        tick(2);
        check("t4_locked", 32'(locked), 32'd1);
        key_n = 4'b1111;
        tick(8);
        check("t4_unlocked", 32'(locked), 32'd0);
        key_n = 4'b0111;
        expect_ev(1'b0, 4'b1000, 2'd3, cyc + 7);
        tick(8);
        key_n = 4'b1111;
        tick(8);

        // Second press while first is still held is ignored
        key_n = 4'b1011;
        expect_ev(1'b0, 4'b0100, 2'd2, cyc + 7);
        tick(8);
        key_n = 4'b1010;
        tick(8);
        check("t5_held_both", 32'(held), 32'b0101);
        check("t5_still_locked", 32'(locked), 32'd1);
        key_n = 4'b1111;
        tick(8);
        key_n = 4'b1110;
        expect_ev(1'b0, 4'b0001, 2'd0, cyc + 7);
        tick(8);
        key_n = 4'b1111;
        tick(8);

        // Press while disabled locks without an event
        enable = 1'b0;
        key_n  = 4'b1101;
        tick(8);
        check("t6_disabled_locked", 32'(locked), 32'd1);
        check("t6_disabled_held", 32'(held), 32'b0010);
        enable = 1'b1;
        tick(4);
        check("t6_enable_still_locked", 32'(locked), 32'd1);
        key_n = 4'b1111;
        tick(8);
        check("t6_unlocked", 32'(locked), 32'd0);
        key_n = 4'b1101;
        expect_ev(1'b0, 4'b0010, 2'd1, cyc + 7);
        tick(8);
        key_n = 4'b1111;
        tick(8);

        // Reset in the middle of a debounce; key stays down
        key_n = 4'b1011;
        tick(3);
        reset = 1'b1;
        tick(3);
        check("t7_rst_held", 32'(held), 32'd0);
        check("t7_rst_locked", 32'(locked), 32'd0);
        reset = 1'b0;
        expect_ev(1'b0, 4'b0100, 2'd2, cyc + 7);
        tick(5);
        check("t7_held_before", 32'(held), 32'd0);
        tick(3);
        check("t7_locked", 32'(locked), 32'd1);
        key_n = 4'b1111;
        tick(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
